// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks in-flight writes in EX/MEM/WB,
// raises load-use and memory-wait stalls, and publishes a pending-write bitmap.
module hazard_scoreboard (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid_ip,
    input  logic [6:0]  id_instr_opcode_ip,
    input  logic [4:0]  id_rs1_ip,
    input  logic [4:0]  id_rs2_ip,
    input  logic [4:0]  id_rd_ip,
    input  logic [1:0]  id_wb_mux_ip,
    input  logic        dmem_ready_ip,
    input  logic        flush_ip,
    output logic        stall_op,
    output logic [31:0] pending_op,
    output logic [15:0] stall_cnt_op
);

    // Writeback selector encoding (write_back_mux_selector); only NO_WRITEBACK matters here.
    typedef enum logic [1:0] {
        NO_WRITEBACK = 2'd0,
        WB_ALU       = 2'd1,
        WB_MEM       = 2'd2,
        WB_PC4       = 2'd3
    } write_back_mux_selector;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       writes;
        logic       is_load;
    } slot_t;

    localparam slot_t BUBBLE = '{valid: 1'b0, rd: 5'd0, writes: 1'b0, is_load: 1'b0};

    slot_t ex_slot, mem_slot, wb_slot;
    slot_t ex_next, mem_next, wb_next;
    slot_t issue_entry;

    logic        uses_rs1;
    logic        uses_rs2;
    logic        load_use;
    logic        mem_hold;
    logic        issue;
    logic [31:0] pending_next;

    // A slot can only forward a hazard if it really writes a non-zero register.
    function automatic logic slot_matches(input slot_t s, input logic [4:0] src);
        return s.valid && s.writes && (s.rd != 5'd0) && (s.rd == src);
    endfunction

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_instr_opcode_ip)
            OPCODE_OP, OPCODE_BRANCH, OPCODE_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR: begin
                uses_rs1 = 1'b1;
            end
            default: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
        endcase
    end

    always_comb begin
        load_use = id_valid_ip && ex_slot.is_load &&
                   ((uses_rs1 && slot_matches(ex_slot, id_rs1_ip)) ||
                    (uses_rs2 && slot_matches(ex_slot, id_rs2_ip)));
        mem_hold = mem_slot.valid && mem_slot.is_load && !dmem_ready_ip;
        stall_op = !reset && (load_use || mem_hold);
        issue    = id_valid_ip && !stall_op && !flush_ip;
    end

    always_comb begin
        issue_entry         = BUBBLE;
        issue_entry.valid   = 1'b1;
        issue_entry.rd      = id_rd_ip;
        issue_entry.writes  = (id_wb_mux_ip != NO_WRITEBACK);
        issue_entry.is_load = (id_instr_opcode_ip == OPCODE_LOAD);
    end

    // A pending memory access freezes the whole window; otherwise everything advances.
    always_comb begin
        ex_next  = ex_slot;
        mem_next = mem_slot;
        wb_next  = wb_slot;
        if (!mem_hold) begin
            wb_next  = mem_slot;
            mem_next = ex_slot;
            ex_next  = issue ? issue_entry : BUBBLE;
        end
    end

    // Bitmap is built from next-state slots so it lines up with the registered slots.
    always_comb begin
        pending_next = 32'h0;
        for (int r = 1; r < 32; r++) begin
            pending_next[r] = slot_matches(ex_next, r[4:0]) ||
                              slot_matches(mem_next, r[4:0]) ||
                              slot_matches(wb_next, r[4:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_slot      <= BUBBLE;
            mem_slot     <= BUBBLE;
            wb_slot      <= BUBBLE;
            pending_op   <= 32'h0;
            stall_cnt_op <= 16'h0;
        end else begin
            ex_slot    <= ex_next;
            mem_slot   <= mem_next;
            wb_slot    <= wb_next;
            pending_op <= pending_next;
            if (stall_op && (stall_cnt_op != 16'hFFFF)) begin
                stall_cnt_op <= stall_cnt_op + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard: load-use, memory wait,
// pending bitmap, flush, counter saturation and reset behaviour.
module tb_hazard_scoreboard;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [1:0] WB_NONE   = 2'd0;
    localparam logic [1:0] WB_ALU    = 2'd1;
    localparam logic [1:0] WB_MEM    = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [1:0]  id_wb_mux;
    logic        dmem_ready;
    logic        flush;
    logic        stall;
    logic [31:0] pending;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard dut (
        .clk                (clk),
        .reset              (reset),
        .id_valid_ip        (id_valid),
        .id_instr_opcode_ip (id_opcode),
        .id_rs1_ip          (id_rs1),
        .id_rs2_ip          (id_rs2),
        .id_rd_ip           (id_rd),
        .id_wb_mux_ip       (id_wb_mux),
        .dmem_ready_ip      (dmem_ready),
        .flush_ip           (flush),
        .stall_op           (stall),
        .pending_op         (pending),
        .stall_cnt_op       (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] opc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [1:0] wb);
        id_valid  = 1'b1;
        id_opcode = opc;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_rd     = rd;
        id_wb_mux = wb;
    endtask

    task automatic idle();
        id_valid  = 1'b0;
        id_opcode = 7'd0;
        id_rs1    = 5'd0;
        id_rs2    = 5'd0;
        id_rd     = 5'd0;
        id_wb_mux = WB_NONE;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        dmem_ready = 1'b1;
        idle();

        // Reset state, with an instruction sitting in ID
        drive(OP_LOAD, 5'd1, 5'd0, 5'd5, WB_MEM);
        tick();
        tick();
        #1;
        checkOutput("reset_stall", {31'd0, stall}, 32'd0);
        checkOutput("reset_pending", pending, 32'h0);
        checkOutput("reset_cnt", {16'd0, stall_cnt}, 32'd0);

        // Load-use: LOAD x5 issues on the first cycle out of reset
        reset = 1'b0;
        #1;
        checkOutput("lu_no_stall_load", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("lu_first_issue", pending, 32'h20);
        drive(OP_OP, 5'd5, 5'd0, 5'd6, WB_ALU);
        #1;
        checkOutput("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        checkOutput("lu_cnt", {16'd0, stall_cnt}, 32'd1);
        checkOutput("lu_bubble", pending, 32'h20);
        #1;
        checkOutput("lu_stall_gone", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("lu_op_issued", pending, 32'h60);
        idle();
        tick();
        checkOutput("lu_drain1", pending, 32'h40);
        tick();
        tick();
        checkOutput("lu_drain_done", pending, 32'h0);
        checkOutput("lu_cnt_final", {16'd0, stall_cnt}, 32'd1);

        // Memory wait: LOAD x7 in MEM with dmem not ready for 3 cycles
        drive(OP_LOAD, 5'd2, 5'd0, 5'd7, WB_MEM);
        tick();
        dmem_ready = 1'b0;
        idle();
        #1;
        checkOutput("mw_no_stall_yet", {31'd0, stall}, 32'd0);
        tick();
        drive(OP_OP, 5'd1, 5'd2, 5'd10, WB_ALU);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("mw_stall", {31'd0, stall}, 32'd1);
            tick();
            checkOutput("mw_pending_held", pending, 32'h80);
        end
        checkOutput("mw_cnt", {16'd0, stall_cnt}, 32'd4);
        dmem_ready = 1'b1;
        #1;
        checkOutput("mw_release", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("mw_advance", pending, 32'h480);
        idle();
        tick();
        checkOutput("mw_load_retired", pending, 32'h400);
        tick();
        tick();
        checkOutput("mw_drain", pending, 32'h0);

        // No false stalls: OP chain on x3, then LOAD x0 followed by OP reading x0
        drive(OP_OP, 5'd1, 5'd2, 5'd3, WB_ALU);
        tick();
        drive(OP_OP, 5'd1, 5'd2, 5'd3, WB_ALU);
        #1;
        checkOutput("nf_op_op", {31'd0, stall}, 32'd0);
        tick();
        drive(OP_OPIMM, 5'd3, 5'd0, 5'd4, WB_ALU);
        #1;
        checkOutput("nf_opimm", {31'd0, stall}, 32'd0);
        tick();
        drive(OP_LOAD, 5'd1, 5'd0, 5'd0, WB_MEM);
        tick();
        checkOutput("nf_pending", pending, 32'h18);
        drive(OP_OP, 5'd0, 5'd0, 5'd8, WB_ALU);
        #1;
        checkOutput("nf_load_x0", {31'd0, stall}, 32'd0);
        tick();
        idle();
        tick();
        tick();
        tick();
        checkOutput("nf_cnt", {16'd0, stall_cnt}, 32'd4);
        checkOutput("nf_drain", pending, 32'h0);

        // Pending bitmap lifetime for x9, then a STORE that writes nothing
        drive(OP_OP, 5'd1, 5'd2, 5'd9, WB_ALU);
        tick();
        idle();
        for (int i = 1; i <= 3; i++) begin
            checkOutput("pb_x9_set", pending, 32'h200);
            tick();
        end
        checkOutput("pb_x9_clear", pending, 32'h0);
        drive(OP_STORE, 5'd1, 5'd2, 5'd9, WB_NONE);
        tick();
        idle();
        checkOutput("pb_store", pending, 32'h0);

        // Two writers of x12: bit stays until the second leaves WB
        drive(OP_OP, 5'd1, 5'd2, 5'd12, WB_ALU);
        tick();
        tick();
        idle();
        tick();
        tick();
        checkOutput("multi_x12_held", pending, 32'h1000);
        tick();
        checkOutput("multi_x12_clear", pending, 32'h0);

        // Flush kills LOAD x4 in ID
        drive(OP_LOAD, 5'd1, 5'd0, 5'd4, WB_MEM);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("fl_pending", pending, 32'h0);
        drive(OP_OP, 5'd4, 5'd0, 5'd11, WB_ALU);
        #1;
        checkOutput("fl_no_stall", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("fl_next_issue", pending, 32'h800);
        idle();
        tick();
        tick();
        tick();

        // Reset mid-operation discards a load held in MEM
        drive(OP_LOAD, 5'd1, 5'd0, 5'd13, WB_MEM);
        tick();
        idle();
        dmem_ready = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checkOutput("rm_stall_forced", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("rm_pending", pending, 32'h0);
        checkOutput("rm_cnt", {16'd0, stall_cnt}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("rm_slots_cleared", {31'd0, stall}, 32'd0);

        // Saturation: hold a load in MEM for 70000 cycles
        dmem_ready = 1'b1;
        drive(OP_LOAD, 5'd1, 5'd0, 5'd7, WB_MEM);
        tick();
        idle();
        dmem_ready = 1'b0;
        tick();
        #1;
        checkOutput("sat_stall", {31'd0, stall}, 32'd1);
        repeat (70000) tick();
        checkOutput("sat_cnt", {16'd0, stall_cnt}, 32'hFFFF);
        checkOutput("sat_pending", pending, 32'h80);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("sat_rst_pending", pending, 32'h0);
        checkOutput("sat_rst_cnt", {16'd0, stall_cnt}, 32'd0);
        #1;
        checkOutput("sat_rst_stall", {31'd0, stall}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
